// File: rtl/mem_pkg.sv
// Shared definitions for the word-organised memory: size encodings, store FSM states
// and the big-endian byte lane ordering that is also used by the fetch path.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    // Lane that holds byte offset 0 of a word: lane 3 = bits [31:24] (big-endian).
    localparam int unsigned LANE_OF_BYTE0 = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2
    } state_t;

endpackage

// File: rtl/store_lane_align.sv
// Positions right-justified store data onto big-endian byte lanes of an 8-byte window
// starting at the word of the first byte; the upper half is the low word, the lower half the next.
module store_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    output logic [3:0]  lo_mask,
    output logic [3:0]  hi_mask,
    output logic [31:0] lo_data,
    output logic [31:0] hi_data,
    output logic        split
);

    logic [3:0]  base_mask;
    logic [31:0] data_left;
    logic [7:0]  win_mask;
    logic [63:0] win_data;

    always_comb begin
        base_mask = '0;
        data_left = '0;
        case (size)
            SZ_BYTE: begin
                base_mask = 4'(1) << LANE_OF_BYTE0;
                data_left = {data[7:0], 24'h0};
            end
            SZ_HALF: begin
                base_mask = (4'(1) << LANE_OF_BYTE0) | (4'(1) << (LANE_OF_BYTE0 - 1));
                data_left = {data[15:0], 16'h0};
            end
            SZ_WORD: begin
                base_mask = 4'hF;
                data_left = data;
            end
            default: begin
                base_mask = '0;
                data_left = '0;
            end
        endcase
        // Shifting right moves bytes toward higher addresses in big-endian order.
        win_mask = {base_mask, 4'h0} >> offset;
        win_data = {data_left, 32'h0} >> {offset, 3'b000};
    end

    assign lo_mask = win_mask[7:4];
    assign hi_mask = win_mask[3:0];
    assign lo_data = win_data[63:32];
    assign hi_data = win_data[31:0];
    assign split   = |win_mask[3:0];

endmodule

// File: rtl/unaligned_store_unit.sv
// Byte-addressed store port into a word array: splits boundary-crossing stores into two
// byte-masked word writes, reports completion/error, and offers a registered word readback.
module unaligned_store_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        done,
    output logic        err,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output state_t      dbg_state
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Handshake: a request transfers on a posedge where req_valid && req_ready; the requester
    // holds its fields until then, and req_ready stays low from acceptance until done.

    logic [31:0] mem [MEM_WORDS];

    state_t        state;
    logic [AW-1:0] idx_q;
    logic [3:0]    lo_mask_q, hi_mask_q;
    logic [31:0]   lo_data_q, hi_data_q;
    logic          split_q, err_q;

    logic [3:0]  a_lo_mask, a_hi_mask;
    logic [31:0] a_lo_data, a_hi_data;
    logic        a_split;

    store_lane_align u_align (
        .offset  (req_addr[1:0]),
        .size    (req_size),
        .data    (req_data),
        .lo_mask (a_lo_mask),
        .hi_mask (a_hi_mask),
        .lo_data (a_lo_data),
        .hi_data (a_hi_data),
        .split   (a_split)
    );

    logic [29:0] req_word;
    logic        req_bad;

    always_comb begin
        req_word = req_addr[31:2];
        req_bad  = (req_size == SZ_ILL)
                || (req_word >= 30'(MEM_WORDS))
                || (a_split && (({1'b0, req_word} + 31'd1) >= 31'(MEM_WORDS)));
    end

    assign req_ready = (state == ST_IDLE) && !rst;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            idx_q     <= '0;
            lo_mask_q <= '0;
            hi_mask_q <= '0;
            lo_data_q <= '0;
            hi_data_q <= '0;
            split_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        idx_q     <= req_word[AW-1:0];
                        lo_mask_q <= a_lo_mask;
                        hi_mask_q <= a_hi_mask;
                        lo_data_q <= a_lo_data;
                        hi_data_q <= a_hi_data;
                        split_q   <= a_split;
                        err_q     <= req_bad;
                        state     <= ST_WR_LO;
                    end
                end
                ST_WR_LO: begin
                    if (split_q && !err_q) begin
                        state <= ST_WR_HI;
                    end else begin
                        done  <= 1'b1;
                        err   <= err_q;
                        state <= ST_IDLE;
                    end
                end
                ST_WR_HI: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;

    // Writes are gated by rst so a reset landing on WR_HI drops the second word.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_mask = lo_mask_q;
        wr_data = lo_data_q;
        if (!rst && state == ST_WR_LO && !err_q) begin
            wr_en = 1'b1;
        end else if (!rst && state == ST_WR_HI) begin
            wr_en   = 1'b1;
            wr_idx  = idx_q + AW'(1);
            wr_mask = hi_mask_q;
            wr_data = hi_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    logic [29:0] rd_word;
    logic        unused_rd_low;

    assign rd_word       = rd_addr[31:2];
    assign unused_rd_low = ^rd_addr[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_word < 30'(MEM_WORDS)) begin
            rd_data <= mem[rd_word[AW-1:0]];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_unaligned_store_unit.sv
// Directed bench for unaligned_store_unit: hand-computed memory images, timing and error cases.
module tb_unaligned_store_unit;
    import mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        done;
    logic        err;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    state_t      dbg_state;

    int checks = 0;
    int errors = 0;

    unaligned_store_unit #(.MEM_WORDS(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .done      (done),
        .err       (err),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen (or after a budget).
    task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input int exp_cyc, input logic exp_err);
        int   cyc;
        int   ready_low;
        logic got;
        logic e;
        cyc = 0; ready_low = 0; got = 1'b0; e = 1'b0;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        req_valid = 1'b1;
        check({tag, " ready_before"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        while (!got && cyc < 10) begin
            @(negedge clk);
            req_valid = 1'b0;
            cyc++;
            if (!req_ready) ready_low++;
            if (done) begin
                got = 1'b1;
                e   = err;
            end
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " done_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " ready_low"}, 32'(ready_low), 32'(exp_cyc - 1));
        check({tag, " err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic read_word(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd_addr = a;
        @(posedge clk);
        @(negedge clk);
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_ready_low", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        @(negedge clk);

        // 1: aligned word store
        do_store("t1_word", 32'h10, 32'hDEADBEEF, SZ_WORD, 2, 1'b0);
        read_word("t1_mem4", 32'h10, 32'hDEADBEEF);

        // 2: byte store into last lane
        do_store("t2_init", 32'h10, 32'h11223344, SZ_WORD, 2, 1'b0);
        do_store("t2_byte", 32'h13, 32'h000000AA, SZ_BYTE, 2, 1'b0);
        read_word("t2_mem4", 32'h12, 32'h112233AA);

        // 3: split word store
        do_store("t3_z3", 32'h0C, 32'h0, SZ_WORD, 2, 1'b0);
        do_store("t3_z4", 32'h10, 32'h0, SZ_WORD, 2, 1'b0);
        do_store("t3_split", 32'h0E, 32'hCAFEBABE, SZ_WORD, 3, 1'b0);
        read_word("t3_mem3", 32'h0C, 32'h0000CAFE);
        read_word("t3_mem4", 32'h10, 32'hBABE0000);

        // 4: split half store
        do_store("t4_i1", 32'h04, 32'h11111111, SZ_WORD, 2, 1'b0);
        do_store("t4_i2", 32'h08, 32'h22222222, SZ_WORD, 2, 1'b0);
        do_store("t4_half", 32'h07, 32'h00001234, SZ_HALF, 3, 1'b0);
        read_word("t4_mem1", 32'h04, 32'h11111112);
        read_word("t4_mem2", 32'h0B, 32'h34222222);

        // 5: errors at top of memory and illegal size
        do_store("t5_i255", 32'h3FC, 32'h55667788, SZ_WORD, 2, 1'b0);
        do_store("t5_i0", 32'h00, 32'h0BADF00D, SZ_WORD, 2, 1'b0);
        do_store("t5_word_top", 32'h3FE, 32'hFFFFFFFF, SZ_WORD, 2, 1'b1);
        read_word("t5_mem255_a", 32'h3FC, 32'h55667788);
        do_store("t5_half_top", 32'h3FF, 32'h0000FFFF, SZ_HALF, 2, 1'b1);
        read_word("t5_mem255_b", 32'h3FC, 32'h55667788);
        do_store("t5_size3", 32'h00, 32'hFFFFFFFF, SZ_ILL, 2, 1'b1);
        read_word("t5_mem0", 32'h00, 32'h0BADF00D);
        do_store("t5_oob_byte", 32'h400, 32'h000000EE, SZ_BYTE, 2, 1'b1);
        do_store("t5_top_byte", 32'h3FF, 32'h000000EE, SZ_BYTE, 2, 1'b0);
        read_word("t5_mem255_c", 32'h3FC, 32'h556677EE);
        read_word("t5_rd_oob", 32'h400, 32'h0);

        // 6: reset during WR_HI drops the second word
        do_store("t6_z3", 32'h0C, 32'h0, SZ_WORD, 2, 1'b0);
        do_store("t6_i4", 32'h10, 32'h44444444, SZ_WORD, 2, 1'b0);
        req_addr = 32'h0E; req_data = 32'hCAFEBABE; req_size = SZ_WORD; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_in_wr_hi", 32'(dbg_state), 32'(ST_WR_HI));
        rst = 1'b1;
        @(negedge clk);
        check("t6_no_done", 32'(done), 32'd0);
        check("t6_no_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("t6_no_done_late", 32'(done), 32'd0);
        read_word("t6_mem3", 32'h0C, 32'h0000CAFE);
        read_word("t6_mem4", 32'h10, 32'h44444444);

        // back-to-back: second request issued in the done cycle of the first
        do_store("t6_bb1", 32'h20, 32'hA1B2C3D4, SZ_WORD, 2, 1'b0);
        do_store("t6_bb2", 32'h21, 32'h00005A5A, SZ_HALF, 2, 1'b0);
        @(negedge clk);
        check("t6_done_pulse", 32'(done), 32'd0);
        read_word("t6_mem8", 32'h20, 32'hA15A5AD4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
